ysyx_22040125_pipe_skid: RTL and testbench

YSYX_22040125_PIPE_SKID -- requirements
Module: ysyx_22040125_PIPE_SKID

---
 rtl/ysyx_22040125_pipe_skid.sv | 157 +++++++++++++++
 tb/tb_ysyx_22040125_pipe_skid.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040125_pipe_skid.sv
// Valid/ready pipeline stage holding instruction + PC, with a bubble counter.
// Define YSYX_22040125_PIPE_SKID_EN for the two-entry (main + skid) variant with registered in_ready.
module ysyx_22040125_pipe_skid #(
    parameter int unsigned        INST_W      = 32,
    parameter int unsigned        PC_W        = 64,
    parameter logic [INST_W-1:0]  BUBBLE_INST = {INST_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [31:0]       bubble_cnt
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state;
    logic   up_xfer;
    logic   dn_xfer;

    assign up_xfer = in_valid & in_ready;
    assign dn_xfer = out_valid & out_ready;

`ifdef YSYX_22040125_PIPE_SKID_EN
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;

    // out_inst/out_pc are the main entry; skid catches the entry accepted while main is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_inst  <= '0;
            out_pc    <= '0;
            skid_inst <= '0;
            skid_pc   <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_inst  <= BUBBLE_INST;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                        out_inst  <= in_inst;
                        out_pc    <= in_pc;
                    end else begin
                        out_inst  <= BUBBLE_INST;
                    end
                end
                ST_ONE: begin
                    if (up_xfer && dn_xfer) begin
                        out_inst <= in_inst;
                        out_pc   <= in_pc;
                    end else if (up_xfer) begin
                        state     <= ST_FULL;
                        in_ready  <= 1'b0;
                        skid_inst <= in_inst;
                        skid_pc   <= in_pc;
                    end else if (dn_xfer) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                        out_inst  <= BUBBLE_INST;
                    end
                end
                ST_FULL: begin
                    if (dn_xfer) begin
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                        out_inst <= skid_inst;
                        out_pc   <= skid_pc;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    out_inst  <= BUBBLE_INST;
                end
            endcase
        end
    end
`else
    // Single entry: accept whenever the held entry leaves this cycle or none is held
    assign in_ready = out_ready | ~out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_inst  <= BUBBLE_INST;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                        out_inst  <= in_inst;
                        out_pc    <= in_pc;
                    end else begin
                        out_inst  <= BUBBLE_INST;
                    end
                end
                ST_ONE: begin
                    if (dn_xfer) begin
                        if (up_xfer) begin
                            out_inst <= in_inst;
                            out_pc   <= in_pc;
                        end else begin
                            state     <= ST_EMPTY;
                            out_valid <= 1'b0;
                            out_inst  <= BUBBLE_INST;
                        end
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    out_inst  <= BUBBLE_INST;
                end
            endcase
        end
    end
`endif

    // Cycles without a presented entry, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_22040125_pipe_skid.sv
// Directed self-checking bench for ysyx_22040125_pipe_skid; expectations follow YSYX_22040125_PIPE_SKID_EN.
module tb_ysyx_22040125_pipe_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [31:0] bubble_cnt;

    int n_checks;
    int n_errors;
    logic acc;

    logic        bp_or    [0:5];
    logic        bp_valid [0:5];
    logic [31:0] bp_inst  [0:5];
    logic [63:0] bp_pc    [0:5];
    logic        bp_rdy   [0:5];
    logic        bp_rdy_release;

    ysyx_22040125_pipe_skid dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Records the upstream handshake, then advances one clock and samples after the edge
    task automatic tick();
        #1;
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        acc = 1'b0;
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_inst = '0;
        in_pc = '0;
        out_ready = 1'b0;

        bp_or    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bp_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bp_inst  = '{32'h100, 32'h100, 32'h100, 32'h101, 32'h102, 32'hFFFF_FFFF};
        bp_pc    = '{64'h1000, 64'h1000, 64'h1000, 64'h1004, 64'h1008, 64'h1008};
`ifdef YSYX_22040125_PIPE_SKID_EN
        bp_rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bp_rdy_release = 1'b0;
`else
        bp_rdy   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bp_rdy_release = 1'b1;
`endif

        // Reset values, applied asynchronously
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_bubble", 64'(bubble_cnt), 64'd0);
        #8 rst = 1'b0;

        // Idle counting
        for (int i = 0; i < 10; i++) tick();
        check("idle_bubble10", 64'(bubble_cnt), 64'd10);
        check("idle_out_inst", 64'(out_inst), 64'hFFFF_FFFF);
        check("idle_out_pc", out_pc, 64'd0);

        // Streaming
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1;
            in_inst  = 32'h13 + 32'(n);
            in_pc    = 64'h8000_0000 + 64'(4 * n);
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_inst", 64'(out_inst), 64'h13 + 64'(n));
            check("stream_pc", out_pc, 64'h8000_0000 + 64'(4 * n));
            check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_bubble", 64'(bubble_cnt), 64'd11);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_inst", 64'(out_inst), 64'hFFFF_FFFF);
        check("drain_pc", out_pc, 64'h8000_0010);
        check("drain_bubble", 64'(bubble_cnt), 64'd11);

        // Backpressure: entries A/B/C offered under the valid/ready protocol
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 6; c++) begin
                out_ready = bp_or[c];
                if (idx < 3) begin
                    in_valid = 1'b1;
                    in_inst  = 32'h100 + 32'(idx);
                    in_pc    = 64'h1000 + 64'(4 * idx);
                end else begin
                    in_valid = 1'b0;
                end
                if (c == 3) begin
                    #1;
                    check("bp_release_in_ready", 64'(in_ready), 64'(bp_rdy_release));
                end
                tick();
                if (acc) idx++;
                check("bp_valid", 64'(out_valid), 64'(bp_valid[c]));
                check("bp_inst", 64'(out_inst), 64'(bp_inst[c]));
                check("bp_pc", out_pc, bp_pc[c]);
                check("bp_in_ready", 64'(in_ready), 64'(bp_rdy[c]));
            end
            check("bp_accepted", 64'(idx), 64'd3);
            check("bp_bubble", 64'(bubble_cnt), 64'd12);
        end

        // Flush while holding entries, with an input offered in the flush cycle
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = 32'h200;
        in_pc = 64'h2000;
        tick();
        check("fl_d_valid", 64'(out_valid), 64'd1);
        check("fl_d_inst", 64'(out_inst), 64'h200);
        in_inst = 32'h201;
        in_pc = 64'h2004;
        tick();
        check("fl_hold_inst", 64'(out_inst), 64'h200);
        check("fl_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        in_inst = 32'h202;
        in_pc = 64'h2008;
        tick();
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_inst", 64'(out_inst), 64'hFFFF_FFFF);
        check("fl_pc", out_pc, 64'h2000);
        check("fl_in_ready_after", 64'(in_ready), 64'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_post_valid", 64'(out_valid), 64'd0);
        check("fl_post_inst", 64'(out_inst), 64'hFFFF_FFFF);
        check("fl_post_pc", out_pc, 64'h2000);
        check("fl_bubble", 64'(bubble_cnt), 64'd14);

        // Asynchronous reset between edges while one entry is held
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = 32'h300;
        in_pc = 64'h3000;
        tick();
        check("ar_pre_valid", 64'(out_valid), 64'd1);
        check("ar_pre_inst", 64'(out_inst), 64'h300);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        check("ar_out_inst", 64'(out_inst), 64'd0);
        check("ar_out_pc", out_pc, 64'd0);
        check("ar_bubble", 64'(bubble_cnt), 64'd0);
        #1 rst = 1'b0;
        in_valid = 1'b1;
        in_inst = 32'h301;
        in_pc = 64'h3004;
        out_ready = 1'b1;
        tick();
        check("ar_first_valid", 64'(out_valid), 64'd1);
        check("ar_first_inst", 64'(out_inst), 64'h301);
        check("ar_first_pc", out_pc, 64'h3004);
        check("ar_first_bubble", 64'(bubble_cnt), 64'd1);

        // Counter saturation
        in_valid = 1'b0;
        tick();
        check("sat_empty", 64'(out_valid), 64'd0);
        force dut.bubble_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt;
        tick();
        check("sat_hold1", 64'(bubble_cnt), 64'hFFFF_FFFF);
        tick();
        check("sat_hold2", 64'(bubble_cnt), 64'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
